// File: rtl/ins_fetch_pkg.sv
// Shared opcodes, FSM states and immediate helpers
// for the instruction fetch stage.
package ins_fetch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef enum logic {
    S_FETCH,
    S_HOLD
  } state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ins_fetch_bht.sv
// Bimodal branch history table of 2-bit saturating
// counters; read is combinational, write is clocked.
module ins_fetch_bht
  import ins_fetch_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] rd_pc_i,
  output logic        rd_taken_o,
  input  logic        upd_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i
);

  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d;
  logic [1:0] cur;
  logic [BHT_BITS-1:0] rd_idx;
  logic [BHT_BITS-1:0] wr_idx;
  logic unused_pc;

  assign rd_idx = rd_pc_i[BHT_BITS+1:2];
  assign wr_idx = upd_pc_i[BHT_BITS+1:2];
  assign unused_pc = ^{rd_pc_i[31:BHT_BITS+2], rd_pc_i[1:0],
                       upd_pc_i[31:BHT_BITS+2], upd_pc_i[1:0]};

  assign rd_taken_o = ctr_q[rd_idx][1];

  always_comb begin
    cur   = ctr_q[wr_idx];
    ctr_d = cur;
    if (upd_taken_i && cur != 2'b11)
      ctr_d = cur + 2'b01;
    else if (!upd_taken_i && cur != 2'b00)
      ctr_d = cur - 2'b01;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < ENTRIES; k++)
        ctr_q[k] <= BHT_INIT;
    end else if (rdy_in && upd_i) begin
      ctr_q[wr_idx] <= ctr_d;
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC, fetch/hold FSM,
// bimodal + static JAL next-PC prediction.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int          BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_data,
  input  logic        f_stall,
  output logic        is_ins,
  output logic [31:0] ins_addr,
  output logic [31:0] ins,
  output logic        pred_jmp,
  output logic [31:0] pred_another,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        rob_br_upd,
  input  logic [31:0] rob_br_pc,
  input  logic        rob_br_taken
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_q, next_d;
  logic        is_ins_q, is_ins_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] addr_q, addr_d;
  logic        pj_q, pj_d;
  logic [31:0] an_q, an_d;

  logic        bht_taken;
  logic [6:0]  opcode;
  logic [31:0] seq_pc;
  logic [31:0] br_tgt;
  logic [31:0] jal_tgt;
  logic        p_jmp;
  logic [31:0] p_next;
  logic [31:0] p_an;

  ins_fetch_bht #(
    .BHT_BITS(BHT_BITS)
  ) u_bht (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rd_pc_i    (pc_q),
    .rd_taken_o (bht_taken),
    .upd_i      (rob_br_upd),
    .upd_pc_i   (rob_br_pc),
    .upd_taken_i(rob_br_taken)
  );

  // JALR is left to the ROB: it falls through and is fixed by a clear
  always_comb begin
    opcode  = ic_data[6:0];
    seq_pc  = pc_q + 32'd4;
    br_tgt  = pc_q + imm_b(ic_data);
    jal_tgt = pc_q + imm_j(ic_data);
    p_jmp   = 1'b0;
    p_next  = seq_pc;
    p_an    = seq_pc;
    unique case (1'b1)
      (opcode == OP_BRANCH): begin
        if (bht_taken) begin
          p_jmp  = 1'b1;
          p_next = br_tgt;
        end else begin
          p_an   = br_tgt;
        end
      end
      (opcode == OP_JAL): begin
        p_jmp  = 1'b1;
        p_next = jal_tgt;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    next_d   = next_q;
    is_ins_d = is_ins_q;
    ins_d    = ins_q;
    addr_d   = addr_q;
    pj_d     = pj_q;
    an_d     = an_q;
    if (rob_clear) begin
      pc_d     = rob_new_pc;
      is_ins_d = 1'b0;
      state_d  = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (ic_valid) begin
            ins_d    = ic_data;
            addr_d   = pc_q;
            pj_d     = p_jmp;
            an_d     = p_an;
            next_d   = p_next;
            is_ins_d = 1'b1;
            state_d  = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!f_stall) begin
            is_ins_d = 1'b0;
            pc_d     = next_q;
            state_d  = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      next_q   <= RESET_PC;
      is_ins_q <= 1'b0;
      ins_q    <= 32'h0;
      addr_q   <= 32'h0;
      pj_q     <= 1'b0;
      an_q     <= 32'h0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      next_q   <= next_d;
      is_ins_q <= is_ins_d;
      ins_q    <= ins_d;
      addr_q   <= addr_d;
      pj_q     <= pj_d;
      an_q     <= an_d;
    end
  end

  assign ic_req       = (state_q == S_FETCH);
  assign ic_addr      = pc_q;
  assign is_ins       = is_ins_q;
  assign ins_addr     = addr_q;
  assign ins          = ins_q;
  assign pred_jmp     = pj_q;
  assign pred_another = an_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed vector table,
// hand-written corner sequences, then random traffic vs a model.
module tb_ins_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_data;
  logic        f_stall;
  logic        is_ins;
  logic [31:0] ins_addr;
  logic [31:0] ins;
  logic        pred_jmp;
  logic [31:0] pred_another;
  logic        rob_clear;
  logic [31:0] rob_new_pc;
  logic        rob_br_upd;
  logic [31:0] rob_br_pc;
  logic        rob_br_taken;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] JAL  = 32'h1000006F;
  localparam logic [31:0] BEQ  = 32'hFE000CE3;

  ins_fetch dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .ic_req      (ic_req),
    .ic_addr     (ic_addr),
    .ic_valid    (ic_valid),
    .ic_data     (ic_data),
    .f_stall     (f_stall),
    .is_ins      (is_ins),
    .ins_addr    (ins_addr),
    .ins         (ins),
    .pred_jmp    (pred_jmp),
    .pred_another(pred_another),
    .rob_clear   (rob_clear),
    .rob_new_pc  (rob_new_pc),
    .rob_br_upd  (rob_br_upd),
    .rob_br_pc   (rob_br_pc),
    .rob_br_taken(rob_br_taken)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic        v;
    logic [31:0] d;
    logic        s;
    logic        c;
    logic [31:0] np;
    logic        e_is;
    logic [31:0] e_addr;
    logic        e_pj;
    logic [31:0] e_an;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic s, input logic c, input logic [31:0] np);
    rdy_in     = r;
    ic_valid   = v;
    ic_data    = d;
    f_stall    = s;
    rob_clear  = c;
    rob_new_pc = np;
  endtask

  task automatic upd(input logic u, input logic [31:0] p, input logic t);
    rob_br_upd   = u;
    rob_br_pc    = p;
    rob_br_taken = t;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // reference predictor from the ISA immediate layouts
  function automatic void predict(input logic [31:0] pc, input logic [31:0] i,
                                  input int ctr, output logic pj,
                                  output logic [31:0] nx, output logic [31:0] an);
    int ib;
    int ij;
    logic [31:0] seq;
    seq = pc + 32'd4;
    ib = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    ij = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    pj = 1'b0;
    nx = seq;
    an = seq;
    if (i[6:0] == 7'h63) begin
      if (ctr >= 2) begin
        pj = 1'b1;
        nx = pc + 32'(ib);
      end else begin
        an = pc + 32'(ib);
      end
    end else if (i[6:0] == 7'h6F) begin
      pj = 1'b1;
      nx = pc + 32'(ij);
    end
  endfunction

  logic        m_hold;
  logic [31:0] m_pc, m_next, m_addr, m_ins, m_an;
  logic        m_is, m_pj;
  int          m_bht [64];

  initial begin
    tbl[0] = '{1'b1, 1'b1, ADDI, 1'b0, 1'b0, 32'h0,
               1'b1, 32'h0, 1'b0, 32'h4, 32'h0};
    tbl[1] = '{1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'h0,
               1'b0, 32'h0, 1'b0, 32'h4, 32'h4};
    tbl[2] = '{1'b1, 1'b1, ADDI, 1'b0, 1'b1, 32'h20,
               1'b0, 32'h0, 1'b0, 32'h4, 32'h20};
    tbl[3] = '{1'b1, 1'b1, JAL, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h20, 1'b1, 32'h24, 32'h20};
    tbl[4] = '{1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'h0,
               1'b0, 32'h20, 1'b1, 32'h24, 32'h120};
    tbl[5] = '{1'b1, 1'b1, ADDI, 1'b0, 1'b1, 32'h200,
               1'b0, 32'h20, 1'b1, 32'h24, 32'h200};
    tbl[6] = '{1'b1, 1'b1, ADDI, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h200, 1'b0, 32'h204, 32'h200};
    tbl[7] = '{1'b1, 1'b0, ADDI, 1'b0, 1'b1, 32'h40,
               1'b0, 32'h200, 1'b0, 32'h204, 32'h40};
    tbl[8] = '{1'b1, 1'b1, BEQ, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h40, 1'b0, 32'h38, 32'h40};
    tbl[9] = '{1'b1, 1'b0, ADDI, 1'b0, 1'b0, 32'h0,
               1'b0, 32'h40, 1'b0, 32'h38, 32'h44};

    rst_in = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 1'b0);
    #12;
    rst_in = 1'b0;
    #1;
    chk("rst_is_ins", {31'h0, is_ins}, 32'h0);
    chk("rst_ic_req", {31'h0, ic_req}, 32'h1);
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_addr", ins_addr, 32'h0);
    chk("rst_pred_jmp", {31'h0, pred_jmp}, 32'h0);
    chk("rst_pred_another", pred_another, 32'h0);

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].rdy, tbl[k].v, tbl[k].d, tbl[k].s, tbl[k].c, tbl[k].np);
      tick();
      chk($sformatf("vec%0d_is_ins", k), {31'h0, is_ins}, {31'h0, tbl[k].e_is});
      chk($sformatf("vec%0d_ins_addr", k), ins_addr, tbl[k].e_addr);
      chk($sformatf("vec%0d_pred_jmp", k), {31'h0, pred_jmp}, {31'h0, tbl[k].e_pj});
      chk($sformatf("vec%0d_pred_another", k), pred_another, tbl[k].e_an);
      chk($sformatf("vec%0d_ic_addr", k), ic_addr, tbl[k].e_pc);
    end

    // stall for five cycles in HOLD
    drive(1'b1, 1'b1, ADDI, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_is_ins", {31'h0, is_ins}, 32'h1);
      chk("stall_ins_addr", ins_addr, 32'h44);
      chk("stall_ins", ins, ADDI);
      chk("stall_ic_req", {31'h0, ic_req}, 32'h0);
    end
    f_stall = 1'b0;
    tick();
    chk("release_is_ins", {31'h0, is_ins}, 32'h0);
    chk("release_ic_addr", ic_addr, 32'h48);

    // train the BHT at 0x40 to taken, then refetch the BEQ
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    upd(1'b1, 32'h40, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, BEQ, 1'b1, 1'b0, 32'h0);
    tick();
    chk("bht_pred_jmp", {31'h0, pred_jmp}, 32'h1);
    chk("bht_pred_another", pred_another, 32'h44);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bht_next_ic_addr", ic_addr, 32'h38);

    // frozen while rdy_in is low, even against a clear
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, ADDI, 1'b0, k == 1, 32'h300);
      tick();
      chk("frz_is_ins", {31'h0, is_ins}, 32'h0);
      chk("frz_ic_addr", ic_addr, 32'h38);
    end
    drive(1'b1, 1'b1, ADDI, 1'b1, 1'b0, 32'h0);
    tick();
    chk("resume_is_ins", {31'h0, is_ins}, 32'h1);
    chk("resume_ins_addr", ins_addr, 32'h38);
    chk("resume_ins", ins, ADDI);

    // asynchronous reset, then randomized traffic against the model
    rst_in = 1'b1;
    #1;
    chk("async_rst_is_ins", {31'h0, is_ins}, 32'h0);
    chk("async_rst_ic_addr", ic_addr, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    rst_in = 1'b0;
    m_hold = 1'b0;
    m_pc = 32'h0;
    m_next = 32'h0;
    m_is = 1'b0;
    m_addr = 32'h0;
    m_ins = 32'h0;
    m_pj = 1'b0;
    m_an = 32'h0;
    for (int k = 0; k < 64; k++) m_bht[k] = 1;

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [31:0] d;
      logic        pj;
      logic [31:0] nx, an;
      int          bi;
      case ($urandom_range(0, 3))
        0: d = {$urandom() & 32'hFFFF_FF80} | 32'h13;
        1: d = {$urandom() & 32'hFFFF_FF80} | 32'h6F;
        2: d = {$urandom() & 32'hFFFF_FF80} | 32'h63;
        default: d = {$urandom() & 32'hFFFF_FF80} | 32'h67;
      endcase
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, d,
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
            32'($urandom_range(0, 255)) << 2);
      upd($urandom_range(0, 9) < 3, 32'($urandom_range(0, 255)) << 2,
          $urandom_range(0, 1) == 1);
      #1;
      chk("rnd_ic_req", {31'h0, ic_req}, {31'h0, !m_hold});
      chk("rnd_ic_addr", ic_addr, m_pc);

      predict(m_pc, ic_data, m_bht[m_pc[7:2]], pj, nx, an);
      if (rdy_in) begin
        if (rob_clear) begin
          m_pc = rob_new_pc;
          m_is = 1'b0;
          m_hold = 1'b0;
        end else if (!m_hold && ic_valid) begin
          m_ins = ic_data;
          m_addr = m_pc;
          m_pj = pj;
          m_an = an;
          m_next = nx;
          m_is = 1'b1;
          m_hold = 1'b1;
        end else if (m_hold && !f_stall) begin
          m_is = 1'b0;
          m_pc = m_next;
          m_hold = 1'b0;
        end
        if (rob_br_upd) begin
          bi = int'(rob_br_pc[7:2]);
          if (rob_br_taken) m_bht[bi] = (m_bht[bi] == 3) ? 3 : m_bht[bi] + 1;
          else m_bht[bi] = (m_bht[bi] == 0) ? 0 : m_bht[bi] - 1;
        end
      end

      tick();
      chk("rnd_is_ins", {31'h0, is_ins}, {31'h0, m_is});
      chk("rnd_ins_addr", ins_addr, m_addr);
      chk("rnd_ins", ins, m_ins);
      chk("rnd_pred_jmp", {31'h0, pred_jmp}, {31'h0, m_pj});
      chk("rnd_pred_another", pred_another, m_an);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
